// File: rtl/regs_exec.sv
// regs_exec: single-issue execute/write-back stage in front of a register file.
// Accepts one decoded instruction per valid/ready handshake, reads two operands
// through the register file's combinational read ports, computes an 8-op ALU
// result and issues a one-cycle write on the write port.
//
// Optional feature: define REGS_EXEC_MUL_EN to build the iterative shift-add
// multiplier for op 7. Without it op 7 is a two-cycle NOP (no write, flags held).
//
// Ports:
//   i_CLK, i_RST        clock, synchronous active-high reset
//   i_valid, o_ready    instruction handshake
//   i_op, i_rd, i_rs0, i_rs1, i_imm   decoded instruction fields
//   o_reg0, o_reg1      register-file read addresses
//   i_data0, i_data1    register-file read data
//   o_reg2, o_data2     register-file write address/data (address 0 = no write)
//   o_flag_z, o_flag_c  zero/carry flags
//   o_busy              stage not idle
module regs_exec #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic [ADDR_WIDTH-1:0] i_rs0,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output logic [ADDR_WIDTH-1:0] o_reg0,
    output logic [ADDR_WIDTH-1:0] o_reg1,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic [ADDR_WIDTH-1:0] o_reg2,
    output logic [DATA_WIDTH-1:0] o_data2,
    output logic                  o_flag_z,
    output logic                  o_flag_c,
    output logic                  o_busy
);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpShl = 3'd5;
    localparam logic [2:0] OpLdi = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q, reg0_q, reg1_q;
    logic [DATA_WIDTH-1:0] imm_q, res_q;
    logic                  z_q, c_q;
    logic                  accept;
    logic                  wr_en;

    // ALU signals
    logic [DATA_WIDTH:0]   sum_ext, shl_ext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c, alu_upd;

`ifdef REGS_EXEC_MUL_EN
    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2*DATA_WIDTH-1:0] mcand_q, acc_q, acc_nxt;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]         cnt_q;
    logic                    mul_last;

    assign acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last = (cnt_q == CntW'(DATA_WIDTH - 1));
    assign wr_en    = 1'b1;
`else
    // Without the multiplier, op 7 retires with no register write.
    assign wr_en    = (op_q != OpMul);
`endif

    assign o_ready = ((state_q == StIdle) || (state_q == StWb)) && !i_RST;
    assign accept  = i_valid && o_ready;
    assign o_busy  = (state_q != StIdle);
    assign o_reg0  = reg0_q;
    assign o_reg1  = reg1_q;
    assign o_reg2  = ((state_q == StWb) && wr_en) ? rd_q  : '0;
    assign o_data2 = ((state_q == StWb) && wr_en) ? res_q : '0;
    assign o_flag_z = z_q;
    assign o_flag_c = c_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
`ifdef REGS_EXEC_MUL_EN
            StExec: state_d = (op_q == OpMul) ? StMul : StWb;
            StMul:  if (mul_last) state_d = StWb;
`else
            StExec: state_d = StWb;
            StMul:  state_d = StIdle;
`endif
            StWb:   state_d = accept ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sum_ext = {1'b0, i_data0} + {1'b0, i_data1};
        // Extra top bit catches the last bit shifted out; stays 0 for a zero shift.
        shl_ext = {1'b0, i_data0} << i_data1[2:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_upd = 1'b1;
        unique case (op_q)
            OpAdd: begin
                alu_res = sum_ext[DATA_WIDTH-1:0];
                alu_c   = sum_ext[DATA_WIDTH];
            end
            OpSub: begin
                alu_res = i_data0 - i_data1;
                alu_c   = (i_data0 < i_data1);
            end
            OpAnd: alu_res = i_data0 & i_data1;
            OpOr:  alu_res = i_data0 | i_data1;
            OpXor: alu_res = i_data0 ^ i_data1;
            OpShl: begin
                alu_res = shl_ext[DATA_WIDTH-1:0];
                alu_c   = shl_ext[DATA_WIDTH];
            end
            OpLdi: begin
                alu_res = imm_q;
                alu_upd = 1'b0;
            end
            OpMul: alu_upd = 1'b0;  // flags come from the MUL state, if built
            default: alu_upd = 1'b0;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= StIdle;
            op_q    <= '0;
            rd_q    <= '0;
            reg0_q  <= '0;
            reg1_q  <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
`ifdef REGS_EXEC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= i_op;
                rd_q   <= i_rd;
                reg0_q <= i_rs0;
                reg1_q <= i_rs1;
                imm_q  <= i_imm;
            end
            if (state_q == StExec) begin
                res_q <= alu_res;
                if (alu_upd) begin
                    z_q <= (alu_res == '0);
                    c_q <= alu_c;
                end
            end
`ifdef REGS_EXEC_MUL_EN
            if (state_q == StExec) begin
                mcand_q  <= {{DATA_WIDTH{1'b0}}, i_data0};
                mplier_q <= i_data1;
                acc_q    <= '0;
                cnt_q    <= '0;
            end
            if (state_q == StMul) begin
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (mul_last) begin
                    res_q <= acc_nxt[DATA_WIDTH-1:0];
                    z_q   <= (acc_nxt[DATA_WIDTH-1:0] == '0);
                    c_q   <= (acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
                end
            end
`endif
        end
    end

endmodule
